// File: rtl/dist_priority_queue.sv
// dist_priority_queue: tentative-distance store with decrease-key updates,
// internal visited tracking and a multi-cycle, LANES-wide extract-min scan.

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 3
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef INFINITY
`define INFINITY 16'hFFFF
`endif

// One comparator stage of the scan chain: replaces the running best only on a
// strictly smaller candidate, so an earlier (lower) index wins ties.
module dpq_lane #(
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                   cand_ok,
    input  logic [VALUE_WIDTH-1:0] cand_value,
    input  logic [INDEX_WIDTH-1:0] cand_index,
    input  logic [VALUE_WIDTH-1:0] in_value,
    input  logic [INDEX_WIDTH-1:0] in_index,
    output logic [VALUE_WIDTH-1:0] out_value,
    output logic [INDEX_WIDTH-1:0] out_index
);
    logic take;

    assign take      = cand_ok && (cand_value < in_value);
    assign out_value = take ? cand_value : in_value;
    assign out_index = take ? cand_index : in_index;
endmodule

module dist_priority_queue #(
    parameter int                          MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int                          INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int                          VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int                          LANES       = 4,
    parameter logic [VALUE_WIDTH-1:0]      INF_VALUE   = `INFINITY
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   init_en,
    input  logic [INDEX_WIDTH-1:0] init_index,
    input  logic                   upd_en,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic [VALUE_WIDTH-1:0] upd_value,
    output logic                   upd_taken,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [VALUE_WIDTH-1:0] rd_value,
    input  logic                   pop_req,
    output logic                   pop_valid,
    output logic [INDEX_WIDTH-1:0] pop_index,
    output logic [VALUE_WIDTH-1:0] pop_value,
    output logic                   pop_empty,
    output logic                   busy,
    output logic [MAX_NODES-1:0]   visited
);
    localparam int GROUPS = (MAX_NODES + LANES - 1) / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state_q, state_d;

    logic [MAX_NODES-1:0][VALUE_WIDTH-1:0] dist_q;
    logic [MAX_NODES-1:0]                  visited_q;
    logic [GRP_W-1:0]                      grp_q;
    logic [VALUE_WIDTH-1:0]                best_value_q;
    logic [INDEX_WIDTH-1:0]                best_index_q;
    logic [INDEX_WIDTH-1:0]                pop_index_q;
    logic [VALUE_WIDTH-1:0]                pop_value_q;
    logic                                  pop_empty_q;
    logic                                  upd_taken_q;
    logic                                  upd_ok;
    logic                                  scan_last;

    // Comparator chain: element 0 is the running best, element LANES the
    // best after this cycle's group.
    logic [VALUE_WIDTH-1:0] chain_value [LANES+1];
    logic [INDEX_WIDTH-1:0] chain_index [LANES+1];

    assign chain_value[0] = best_value_q;
    assign chain_index[0] = best_index_q;
    assign scan_last      = (state_q == SCAN) && (grp_q == LAST_GRP);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic                   ok;
        logic [VALUE_WIDTH-1:0] val;
        logic [INDEX_WIDTH-1:0] idx;

        // Fetch this lane's node for the current group; out-of-range nodes stay disabled.
        always_comb begin
            ok  = 1'b0;
            val = INF_VALUE;
            idx = '0;
            for (int n = 0; n < MAX_NODES; n++) begin
                if (n == int'(grp_q) * LANES + l) begin
                    ok  = ~visited_q[n];
                    val = dist_q[n];
                    idx = n[INDEX_WIDTH-1:0];
                end
            end
        end

        dpq_lane #(
            .INDEX_WIDTH(INDEX_WIDTH),
            .VALUE_WIDTH(VALUE_WIDTH)
        ) u_lane (
            .cand_ok   (ok),
            .cand_value(val),
            .cand_index(idx),
            .in_value  (chain_value[l]),
            .in_index  (chain_index[l]),
            .out_value (chain_value[l+1]),
            .out_index (chain_index[l+1])
        );
    end

    // Decide whether this cycle's decrease-key is accepted.
    always_comb begin
        upd_ok = 1'b0;
        for (int n = 0; n < MAX_NODES; n++) begin
            if (n == int'(upd_index))
                upd_ok = ~visited_q[n] && (upd_value < dist_q[n]);
        end
        upd_ok = upd_ok && upd_en && !init_en && (state_q == IDLE);
    end

    // Combinational read port; addresses beyond the table read as unreached.
    always_comb begin
        rd_value = INF_VALUE;
        for (int n = 0; n < MAX_NODES; n++) begin
            if (n == int'(rd_index))
                rd_value = dist_q[n];
        end
    end

    // FSM next state; init_en overrides everything and aborts a scan.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop_req) state_d = SCAN;
            SCAN:    if (grp_q == LAST_GRP) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (init_en)
            state_d = IDLE;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Distance table: init loads the source, accepted updates overwrite.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < MAX_NODES; n++) dist_q[n] <= INF_VALUE;
        end else if (init_en) begin
            for (int n = 0; n < MAX_NODES; n++)
                dist_q[n] <= (n == int'(init_index)) ? '0 : INF_VALUE;
        end else if (upd_ok) begin
            for (int n = 0; n < MAX_NODES; n++)
                if (n == int'(upd_index)) dist_q[n] <= upd_value;
        end
    end

    // Visited bits: cleared by init, set for the popped node as DONE retires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            visited_q <= '0;
        end else if (init_en) begin
            visited_q <= '0;
        end else if (state_q == DONE && !pop_empty_q) begin
            for (int n = 0; n < MAX_NODES; n++)
                if (n == int'(pop_index_q)) visited_q[n] <= 1'b1;
        end
    end

    // Scan progress and running best; held cleared outside SCAN so each scan starts fresh.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grp_q        <= '0;
            best_value_q <= INF_VALUE;
            best_index_q <= '0;
        end else if (init_en || state_q != SCAN) begin
            grp_q        <= '0;
            best_value_q <= INF_VALUE;
            best_index_q <= '0;
        end else begin
            grp_q        <= grp_q + GRP_W'(1);
            best_value_q <= chain_value[LANES];
            best_index_q <= chain_index[LANES];
        end
    end

    // Pop result is captured on the last group and held until the next completed scan.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pop_index_q <= '0;
            pop_value_q <= INF_VALUE;
            pop_empty_q <= 1'b0;
        end else if (scan_last && !init_en) begin
            if (chain_value[LANES] < INF_VALUE) begin
                pop_index_q <= chain_index[LANES];
                pop_value_q <= chain_value[LANES];
                pop_empty_q <= 1'b0;
            end else begin
                pop_index_q <= '0;
                pop_value_q <= INF_VALUE;
                pop_empty_q <= 1'b1;
            end
        end
    end

    // Acknowledge pulse for a written update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) upd_taken_q <= 1'b0;
        else       upd_taken_q <= upd_ok;
    end

    assign upd_taken = upd_taken_q;
    assign pop_valid = (state_q == DONE);
    assign pop_index = pop_index_q;
    assign pop_value = pop_value_q;
    assign pop_empty = pop_empty_q;
    assign busy      = (state_q != IDLE);
    assign visited   = visited_q;
endmodule

// File: tb/tb_dist_priority_queue.sv
// Bench for dist_priority_queue: two instances (LANES=4 and LANES=3) share
// stimulus and are checked against a node-array reference model.
`timescale 1ns/1ps
module tb_dist_priority_queue;
    localparam int MN = 8;
    localparam logic [7:0] INF = 8'hFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       init_en = 1'b0;
    logic [3:0] init_index = '0;
    logic       upd_en = 1'b0;
    logic [3:0] upd_index = '0;
    logic [7:0] upd_value = '0;
    logic [3:0] rd_index = '0;
    logic       pop_req = 1'b0;

    logic       upd_taken, pop_valid, pop_empty, busy;
    logic [7:0] rd_value, pop_value;
    logic [3:0] pop_index;
    logic [7:0] visited;
    logic       upd_taken3, pop_valid3, pop_empty3, busy3;
    logic [7:0] rd_value3, pop_value3;
    logic [3:0] pop_index3;
    logic [7:0] visited3;

    dist_priority_queue #(.MAX_NODES(MN), .INDEX_WIDTH(4), .VALUE_WIDTH(8),
                          .LANES(4), .INF_VALUE(INF)) u_dut (
        .clock(clock), .reset(reset), .init_en(init_en), .init_index(init_index),
        .upd_en(upd_en), .upd_index(upd_index), .upd_value(upd_value),
        .upd_taken(upd_taken), .rd_index(rd_index), .rd_value(rd_value),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_index(pop_index),
        .pop_value(pop_value), .pop_empty(pop_empty), .busy(busy), .visited(visited));

    dist_priority_queue #(.MAX_NODES(MN), .INDEX_WIDTH(4), .VALUE_WIDTH(8),
                          .LANES(3), .INF_VALUE(INF)) u_dut3 (
        .clock(clock), .reset(reset), .init_en(init_en), .init_index(init_index),
        .upd_en(upd_en), .upd_index(upd_index), .upd_value(upd_value),
        .upd_taken(upd_taken3), .rd_index(rd_index), .rd_value(rd_value3),
        .pop_req(pop_req), .pop_valid(pop_valid3), .pop_index(pop_index3),
        .pop_value(pop_value3), .pop_empty(pop_empty3), .busy(busy3), .visited(visited3));

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model: plain distance array and visited mask.
    logic [7:0] mdist [MN];
    logic [7:0] mvis;

    typedef struct { int idx; int val; bit taken; } upd_vec_t;
    upd_vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void m_reset();
        for (int n = 0; n < MN; n++) mdist[n] = INF;
        mvis = '0;
    endfunction

    function automatic void m_init(input int i);
        for (int n = 0; n < MN; n++) mdist[n] = (n == i) ? 8'd0 : INF;
        mvis = '0;
    endfunction

    function automatic bit m_upd(input int i, input int v);
        if (i < MN && !mvis[i] && v < int'(mdist[i])) begin
            mdist[i] = v[7:0];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Minimum over unvisited nodes; ascending scan with strict < picks lowest index on ties.
    task automatic m_best(output bit e, output int idx, output int val);
        e = 1'b1; idx = 0; val = INF;
        for (int n = 0; n < MN; n++)
            if (!mvis[n] && int'(mdist[n]) < val) begin
                e = 1'b0; idx = n; val = mdist[n];
            end
    endtask

    task automatic rd_chk(input string tag, input int i);
        logic [7:0] e;
        rd_index = i[3:0];
        #1;
        e = (i < MN) ? mdist[i] : INF;
        chk({tag, " rd"}, rd_value, e);
        chk({tag, " rd3"}, rd_value3, e);
    endtask

    task automatic do_init(input int i);
        init_en = 1'b1; init_index = i[3:0];
        tick();
        init_en = 1'b0;
        m_init(i);
    endtask

    task automatic do_upd(input string tag, input int i, input int v, output bit tk);
        upd_en = 1'b1; upd_index = i[3:0]; upd_value = v[7:0];
        tk = m_upd(i, v);
        tick();
        upd_en = 1'b0;
        chk({tag, " taken3"}, upd_taken3, tk);
    endtask

    // Issue a pop (optionally with a same-cycle update) and follow both instances to idle.
    task automatic do_pop(input string tag, input bit wu, input int ui, input int uv);
        bit e, tk, g4, g3;
        int ei, ev, c4, c3, n4, n3;
        tk = 0; g4 = 0; g3 = 0; c4 = 0; c3 = 0; n4 = 0; n3 = 0;
        if (wu) begin
            upd_en = 1'b1; upd_index = ui[3:0]; upd_value = uv[7:0];
            tk = m_upd(ui, uv);
        end
        m_best(e, ei, ev);
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0; upd_en = 1'b0;
        if (wu) chk({tag, " taken"}, upd_taken, tk);
        chk({tag, " busy c1"}, busy, 1);
        for (int c = 1; c <= 12; c++) begin
            if (pop_valid) begin
                n4++;
                if (!g4) begin
                    g4 = 1; c4 = c;
                    chk({tag, " empty"}, pop_empty, e);
                    chk({tag, " index"}, pop_index, ei);
                    chk({tag, " value"}, pop_value, ev);
                end
            end
            if (pop_valid3) begin
                n3++;
                if (!g3) begin
                    g3 = 1; c3 = c;
                    chk({tag, " empty3"}, pop_empty3, e);
                    chk({tag, " index3"}, pop_index3, ei);
                    chk({tag, " value3"}, pop_value3, ev);
                end
            end
            if (g4 && g3 && !busy && !busy3) break;
            tick();
        end
        chk({tag, " valid cycle"}, c4, 3);
        chk({tag, " valid cycle L3"}, c3, 4);
        chk({tag, " pulses"}, n4, 1);
        chk({tag, " pulses3"}, n3, 1);
        if (!e) mvis[ei] = 1'b1;
        chk({tag, " visited"}, visited, mvis);
        chk({tag, " visited3"}, visited3, mvis);
    endtask

    initial begin
        bit tk;
        int cnt;

        vecs[0] = '{5, 7, 1};
        vecs[1] = '{1, 7, 1};
        vecs[2] = '{6, 2, 1};
        vecs[3] = '{6, 9, 0};
        vecs[4] = '{3, 0, 0};
        vecs[5] = '{12, 1, 0};
        vecs[6] = '{5, 7, 0};

        // Reset values
        m_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst pop_valid", pop_valid, 0);
        chk("rst pop_empty", pop_empty, 0);
        chk("rst pop_index", pop_index, 0);
        chk("rst pop_value", pop_value, INF);
        chk("rst busy", busy, 0);
        chk("rst upd_taken", upd_taken, 0);
        chk("rst visited", visited, 0);
        rd_chk("rst n2", 2);

        // Source node 3
        do_init(3);
        for (int n = 0; n < MN; n++) rd_chk("init3", n);
        do_pop("pop src", 0, 0, 0);
        chk("visited 3", visited, 8'b0000_1000);

        // Table of relaxations
        for (int k = 0; k < 7; k++) begin
            do_upd($sformatf("vec%0d", k), vecs[k].idx, vecs[k].val, tk);
            chk($sformatf("vec%0d taken", k), upd_taken, vecs[k].taken);
            rd_chk($sformatf("vec%0d", k), vecs[k].idx);
        end
        do_pop("pop n6", 0, 0, 0);
        chk("pop n6 idx", pop_index, 6);
        do_pop("pop n1 tie", 0, 0, 0);
        chk("pop n1 idx", pop_index, 1);
        do_pop("pop n5", 0, 0, 0);
        chk("pop n5 idx", pop_index, 5);
        do_pop("pop empty", 0, 0, 0);
        chk("pop empty flag", pop_empty, 1);

        // Update during SCAN is ignored
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        upd_en = 1'b1; upd_index = 4'd0; upd_value = 8'd1;
        tick();
        upd_en = 1'b0;
        chk("scan upd taken", upd_taken, 0);
        chk("scan upd taken3", upd_taken3, 0);
        cnt = 0;
        while ((busy || busy3) && cnt < 10) begin tick(); cnt++; end
        chk("scan upd idle", busy | busy3, 0);
        rd_chk("scan upd n0", 0);

        // init_en in cycle 1 of SCAN aborts
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        init_en = 1'b1; init_index = 4'd7;
        tick();
        init_en = 1'b0;
        m_init(7);
        chk("abort busy", busy, 0);
        chk("abort busy3", busy3, 0);
        chk("abort visited", visited, 0);
        chk("abort pop_valid", pop_valid, 0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (pop_valid || pop_valid3) cnt++;
            tick();
        end
        chk("abort no valid", cnt, 0);
        rd_chk("abort n7", 7);

        // Out-of-range source: nothing reachable
        do_init(10);
        for (int n = 0; n < MN; n++) rd_chk("init10", n);
        do_pop("pop oor", 0, 0, 0);

        // Update in the same cycle as pop_req is seen by the scan (tie 2 vs 4)
        do_init(4);
        do_pop("pop+upd", 1, 2, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int op, i, v;
            op = $urandom_range(0, 9);
            i  = $urandom_range(0, 11);
            v  = $urandom_range(0, 255);
            if (op < 6) begin
                do_upd("rnd upd", i, v, tk);
                chk("rnd upd taken", upd_taken, tk);
                rd_chk("rnd", i);
            end else if (op < 9) begin
                do_pop("rnd pop", $urandom_range(0, 1), i, v);
            end else begin
                do_init($urandom_range(0, 9));
            end
        end

        // Asynchronous reset in the middle of a scan
        do_init(5);
        do_pop("pop n5b", 0, 0, 0);
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("arst busy", busy, 0);
        chk("arst busy3", busy3, 0);
        chk("arst pop_valid", pop_valid, 0);
        chk("arst pop_index", pop_index, 0);
        chk("arst pop_value", pop_value, INF);
        chk("arst pop_empty", pop_empty, 0);
        chk("arst visited", visited, 0);
        chk("arst visited3", visited3, 0);
        chk("arst upd_taken", upd_taken, 0);
        rd_chk("arst n5", 5);
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        chk("post arst pop_valid", pop_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
